// File: rtl/uart_cmd_host_if.sv
// uart_cmd_host_if: command request and response bundle between a requester and uart_cmd_host
interface uart_cmd_host_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_type;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_data0;
  logic [DATA_WIDTH-1:0]   cmd_data1;
  logic [3:0]              cmd_fun;
  logic                    rsp_valid;
  logic [2*DATA_WIDTH-1:0] rsp_data;
  logic                    rsp_timeout;
  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1, cmd_fun,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_data0, cmd_data1, cmd_fun,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout
  );
endinterface

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: serializes one command into a UART byte frame and collects its response or a timeout
module uart_cmd_host #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_cmd_host_if.slave        cmd,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] RX_P_Data,
  input  logic                  RX_D_VLD
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, RESP, DONE} state_t;
  state_t state, nxt;
  logic [1:0] typ, idx;
  logic rcnt, to_q, accept, last_tx, last_rx, expired;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] d0, d1, tx_byte;
  logic [3:0] fun;
  logic [CW-1:0] tcnt;
  logic [2*DATA_WIDTH-1:0] rsp_q;
  always_comb begin
    accept  = state == IDLE && cmd.cmd_valid;
    last_tx = idx == (typ == 2'd0 ? 2'd2 : typ == 2'd2 ? 2'd3 : 2'd1);
    last_rx = typ == 2'd1 || rcnt;
    // a byte landing on the terminal count wins over the timeout
    expired = !RX_D_VLD && tcnt == CW'(TIMEOUT - 1);
    tx_byte = idx == 2'd0 ? DATA_WIDTH'(typ == 2'd0 ? 8'hAA : typ == 2'd1 ? 8'hBB : typ == 2'd2 ? 8'hCC : 8'hDD)
            : idx == 2'd1 ? (typ == 2'd2 ? d0 : typ == 2'd3 ? DATA_WIDTH'(fun) : DATA_WIDTH'(addr))
            : idx == 2'd2 ? (typ == 2'd2 ? d1 : d0)
            : DATA_WIDTH'(fun);
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? LOAD : IDLE;
      LOAD:    nxt = busy ? LOAD : WAIT_HI;
      WAIT_HI: nxt = busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: nxt = busy ? WAIT_LO : !last_tx ? LOAD : typ == 2'd0 ? DONE : RESP;
      RESP:    nxt = (RX_D_VLD && last_rx) || expired ? DONE : RESP;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    cmd.cmd_ready   = state == IDLE;
    cmd.rsp_valid   = state == DONE;
    cmd.rsp_data    = rsp_q;
    cmd.rsp_timeout = to_q;
    TX_D_VLD        = state == LOAD && !busy;
    TX_P_Data       = state == LOAD || state == WAIT_HI || state == WAIT_LO ? tx_byte : '0;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      typ   <= '0;
      idx   <= '0;
      rcnt  <= 1'b0;
      addr  <= '0;
      d0    <= '0;
      d1    <= '0;
      fun   <= '0;
      tcnt  <= '0;
      rsp_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tcnt <= state == RESP && !RX_D_VLD ? tcnt + 1'b1 : '0;
      if (accept) begin
        typ   <= cmd.cmd_type;
        addr  <= cmd.cmd_addr;
        d0    <= cmd.cmd_data0;
        d1    <= cmd.cmd_data1;
        fun   <= cmd.cmd_fun;
        idx   <= '0;
        rcnt  <= 1'b0;
        rsp_q <= '0;
        to_q  <= 1'b0;
      end
      if (state == WAIT_LO && !busy) idx <= idx + 1'b1;
      if (state == RESP && RX_D_VLD) begin
        rcnt <= 1'b1;
        if (rcnt) rsp_q[2*DATA_WIDTH-1:DATA_WIDTH] <= RX_P_Data;
        else rsp_q[DATA_WIDTH-1:0] <= RX_P_Data;
      end
      if (state == RESP && expired) to_q <= 1'b1;
    end
endmodule

// File: tb/tb_uart_cmd_host.sv
// tb_uart_cmd_host: scoreboard bench with a UART line model, random commands and directed corner cases
module tb_uart_cmd_host;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 4096;
  typedef struct { logic [15:0] d; logic to; } rsp_t;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [DW-1:0] TX_P_Data;
  logic [DW-1:0] RX_P_Data = '0;
  logic TX_D_VLD;
  logic busy = 1'b0;
  logic RX_D_VLD = 1'b0;
  logic [7:0] tx_q[$];
  rsp_t rsp_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int b_start = -10, b_end = -10, g_start = -10, g_end = -10, stab_end = -10;
  int exp_to_cyc = -1, fix_len = 0, m_len, m_gap, m_glen;
  bit glitch_en = 1'b0, prev_rsp = 1'b0;
  logic [7:0] launched = '0;
  logic [15:0] last_d = '0;
  logic last_to = 1'b0;
  rsp_t m_e;
  uart_cmd_host_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifc ();
  uart_cmd_host #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .cmd(ifc), .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD),
    .busy(busy), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // UART transmitter: busy follows scheduled windows, optionally re-raised briefly after a byte
  initial forever begin
    @(posedge CLK);
    #1;
    busy = (cyc >= b_start && cyc <= b_end) || (cyc >= g_start && cyc <= g_end);
  end
  initial begin
    #5ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  function automatic void fail(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction
  function automatic int nresp(logic [1:0] t);
    return t == 2'd0 ? 0 : t == 2'd1 ? 1 : 2;
  endfunction
  always @(negedge CLK) if (RST) begin
    if (TX_D_VLD) begin
      chk("tx_vld_while_busy", busy, 0);
      if (tx_q.size() == 0) fail("tx_unexpected_byte");
      else chk("tx_byte", TX_P_Data, tx_q.pop_front());
      launched = TX_P_Data;
      m_len = fix_len > 0 ? fix_len : int'($urandom_range(1, 6));
      m_gap = $urandom_range(0, 2);
      m_glen = glitch_en && $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0;
      b_start = cyc + 1 + m_gap;
      b_end = b_start + m_len - 1;
      g_start = m_glen > 0 ? b_end + 2 : -10;
      g_end = m_glen > 0 ? g_start + m_glen - 1 : -10;
      stab_end = b_end + 1;
    end else if (cyc <= stab_end) chk("tx_data_stable", TX_P_Data, launched);
    if (ifc.rsp_valid) begin
      chk("cmd_ready_during_rsp", ifc.cmd_ready, 0);
      if (rsp_q.size() == 0) fail("rsp_unexpected");
      else begin
        m_e = rsp_q.pop_front();
        chk("rsp_data", ifc.rsp_data, m_e.d);
        chk("rsp_timeout", ifc.rsp_timeout, m_e.to);
        if (m_e.to && exp_to_cyc >= 0) chk("timeout_cycle", cyc, exp_to_cyc);
        exp_to_cyc = -1;
        last_d = m_e.d;
        last_to = m_e.to;
      end
      prev_rsp = 1'b1;
    end else begin
      if (prev_rsp) chk("cmd_ready_after_rsp", ifc.cmd_ready, 1);
      prev_rsp = 1'b0;
      if (ifc.cmd_ready && ifc.cmd_valid) begin
        chk("rsp_data_hold", ifc.rsp_data, last_d);
        chk("rsp_timeout_hold", ifc.rsp_timeout, last_to);
      end
    end
  end
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d0, d1, input logic [3:0] f);
    int n = 0;
    bit was;
    case (t)
      2'd0: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, a}); tx_q.push_back(d0); end
      2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, a}); end
      2'd2: begin tx_q.push_back(8'hCC); tx_q.push_back(d0); tx_q.push_back(d1); tx_q.push_back({4'h0, f}); end
      default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, f}); end
    endcase
    @(posedge CLK);
    #2;
    ifc.cmd_type = t;
    ifc.cmd_addr = a;
    ifc.cmd_data0 = d0;
    ifc.cmd_data1 = d1;
    ifc.cmd_fun = f;
    ifc.cmd_valid = 1'b1;
    do begin
      was = ifc.cmd_ready;
      @(posedge CLK);
      #2;
      n++;
    end while (!was && n < 200);
    if (!was) fail("cmd_accept_wait");
    ifc.cmd_valid = 1'b0;
    ifc.cmd_type = 2'($urandom);
    ifc.cmd_addr = 4'($urandom);
    ifc.cmd_data0 = 8'($urandom);
    ifc.cmd_data1 = 8'($urandom);
    ifc.cmd_fun = 4'($urandom);
  endtask
  task automatic wait_sent();
    int n = 0;
    while ((tx_q.size() > 0 || cyc <= stab_end) && n < 5000) begin
      RX_D_VLD = tx_q.size() > 0 && $urandom_range(0, 7) == 0;
      RX_P_Data = 8'($urandom);
      @(posedge CLK);
      #2;
      n++;
    end
    RX_D_VLD = 1'b0;
    if (n >= 5000) fail("tx_frame_wait");
  endtask
  task automatic run_cmd(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d0, d1, input logic [3:0] f,
                         input int nsend, input int last_delay, input logic [7:0] r0, r1);
    rsp_t e;
    logic [7:0] rb[2];
    int nr, pc = 0, n = 0;
    nr = nresp(t);
    rb[0] = r0;
    rb[1] = r1;
    e.d = '0;
    for (int i = 0; i < nr && i < nsend; i++) e.d |= 16'(rb[i]) << (8 * i);
    e.to = nsend < nr;
    rsp_q.push_back(e);
    issue(t, a, d0, d1, f);
    wait_sent();
    for (int i = 0; i < nsend && i < nr; i++) begin
      int d = (i == nsend - 1 && last_delay >= 0) ? last_delay : int'($urandom_range(1, 4));
      repeat (d) begin @(posedge CLK); #2; end
      RX_P_Data = rb[i];
      RX_D_VLD = 1'b1;
      pc = cyc;
      @(posedge CLK);
      #2;
      RX_D_VLD = 1'b0;
    end
    if (e.to && nsend > 0) exp_to_cyc = pc + 1 + TO;
    while (rsp_q.size() > 0 && n < TO + 100) begin @(posedge CLK); #2; n++; end
    if (rsp_q.size() > 0) begin
      fail("rsp_wait");
      rsp_q.delete();
    end
    if ($urandom_range(0, 3) == 0) begin
      RX_P_Data = 8'($urandom);
      RX_D_VLD = 1'b1;
      @(posedge CLK);
      #2;
      RX_D_VLD = 1'b0;
    end
  endtask
  initial begin
    int n, ns, nr;
    logic [1:0] t;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_type = '0;
    ifc.cmd_addr = '0;
    ifc.cmd_data0 = '0;
    ifc.cmd_data1 = '0;
    ifc.cmd_fun = '0;
    repeat (3) @(posedge CLK);
    #2;
    chk("reset_cmd_ready", ifc.cmd_ready, 1);
    chk("reset_tx_vld", TX_D_VLD, 0);
    chk("reset_tx_data", TX_P_Data, 0);
    chk("reset_rsp_valid", ifc.rsp_valid, 0);
    chk("reset_rsp_data", ifc.rsp_data, 0);
    chk("reset_rsp_timeout", ifc.rsp_timeout, 0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    run_cmd(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 0, -1, 8'h00, 8'h00);
    run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, -1, 8'h81, 8'h00);
    run_cmd(2'd2, 4'h0, 8'h10, 8'h20, 4'h1, 2, -1, 8'h00, 8'h02);
    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h0, 1, -1, 8'h55, 8'h00);
    fix_len = 50;
    glitch_en = 1'b1;
    run_cmd(2'd2, 4'h7, 8'hA5, 8'h5A, 4'hE, 2, -1, 8'h12, 8'h34);
    fix_len = 0;
    run_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h9, 2, TO - 1, 8'hC3, 8'h3C);
    run_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 0, -1, 8'h00, 8'h00);
    // abandon a type2 frame after its second byte
    issue(2'd2, 4'h3, 8'h11, 8'h22, 4'h4);
    n = 0;
    while (tx_q.size() > 2 && n < 500) begin @(posedge CLK); #2; n++; end
    if (n >= 500) fail("reset_frame_wait");
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("midreset_cmd_ready", ifc.cmd_ready, 1);
    chk("midreset_tx_vld", TX_D_VLD, 0);
    chk("midreset_tx_data", TX_P_Data, 0);
    chk("midreset_rsp_valid", ifc.rsp_valid, 0);
    chk("midreset_rsp_data", ifc.rsp_data, 0);
    tx_q.delete();
    rsp_q.delete();
    b_start = -10;
    b_end = -10;
    g_start = -10;
    g_end = -10;
    stab_end = -10;
    exp_to_cyc = -1;
    prev_rsp = 1'b0;
    last_d = '0;
    last_to = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    RST = 1'b1;
    run_cmd(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1, -1, 8'h6E, 8'h00);
    for (int k = 0; k < 40; k++) begin
      t = 2'($urandom);
      nr = nresp(t);
      ns = nr;
      if (nr > 0 && $urandom_range(0, 15) == 0) ns = $urandom_range(0, nr - 1);
      run_cmd(t, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), ns, -1, 8'($urandom), 8'($urandom));
    end
    repeat (5) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_cmd_host.md
Name: uart_cmd_host

Overview:
- Host-side command initiator for the UART register/ALU command protocol that the system controller executes.
- Accepts one parallel command at a time and serializes it into a byte frame sequence.
- Sends the bytes over a UART TX byte interface, then collects the response bytes from a UART RX byte interface.
- Returns the response, or a timeout flag, to the requester.
- Used in the bench-side host model and in the companion host FPGA design.

Parameters:
- DATA_WIDTH, 8, width of each frame byte.
- ADDR_WIDTH, 4, register-file address width carried in the low bits of the address byte.
- TIMEOUT, 4096, number of CLK cycles to wait for each response byte before aborting.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request; held until accepted.
- cmd_ready  out  1  high in IDLE only; a command is accepted when cmd_valid & cmd_ready.
- cmd_type  in  2  0=RF write, 1=RF read, 2=ALU op with operands, 3=ALU op without operands.
- cmd_addr  in  ADDR_WIDTH  RF address.
- cmd_data0  in  DATA_WIDTH  RF write data, or operand A.
- cmd_data1  in  DATA_WIDTH  operand B.
- cmd_fun  in  4  ALU function.
- TX_P_Data  out  DATA_WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle pulse that launches a byte.
- busy  in  1  UART TX busy (already synchronized to CLK).
- RX_P_Data  in  DATA_WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle pulse; RX_P_Data valid.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  2*DATA_WIDTH  response value.
- rsp_timeout  out  1  valid with rsp_valid; 1 = response aborted on timeout.

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. FSM in IDLE, counters cleared.
- Frames (bytes in send order; address byte = zero-extended cmd_addr, function byte = zero-extended cmd_fun):
  - type0: 0xAA, addr, data0. No response.
  - type1: 0xBB, addr. 1 response byte.
  - type2: 0xCC, data0, data1, fun. 2 response bytes, LSB first.
  - type3: 0xDD, fun. 2 response bytes, LSB first.
- On accept, all cmd_* fields are registered; later changes on the cmd_* inputs are ignored until the next accept.
- States:
  - IDLE: on accept -> LOAD.
  - LOAD: drive TX_P_Data with byte[idx]; when busy=0, pulse TX_D_VLD for 1 cycle -> WAIT_HI.
  - WAIT_HI: wait for busy=1 -> WAIT_LO.
  - WAIT_LO: wait for busy=0. Then idx+1; if bytes remain -> LOAD; else if response count is 0 -> DONE; else -> RESP.
  - RESP: each RX_D_VLD stores RX_P_Data (first byte -> rsp_data[7:0], second -> [15:8]) and reloads the timeout counter. When the last expected byte arrives -> DONE. If the counter reaches TIMEOUT-1 with bytes missing -> DONE with the timeout flag set.
  - DONE: rsp_valid=1 for one cycle -> IDLE.
- TX_P_Data is stable from LOAD until busy falls in WAIT_LO.
- Unused upper rsp_data bits are 0 (type1 => rsp_data[15:8]=0; type0 => rsp_data=0).
- rsp_data and rsp_timeout hold their values until the next accept.
- RX_D_VLD outside RESP is ignored (no capture, no error). The timeout counter starts at 0 on entry to RESP.
- RX_D_VLD on the same cycle as the timeout terminal count: the byte is captured and the timeout does not fire for that byte.
- No TX-side timeout; a stuck busy stalls the FSM (documented limitation).
- Back-to-back: cmd_ready returns 1 in the cycle after rsp_valid. Minimum gap between commands is 1 cycle.
- Reset asserted mid-operation: immediate return to reset values; any partially sent frame is abandoned.

Test Plan:
- RF write: type0, addr=5, data0=0x3C -> TX bytes AA,05,3C, one TX_D_VLD each after busy falls; rsp_valid with rsp_data=0, rsp_timeout=0.
- RF read: type1, addr=2; responder returns 0x81 -> TX BB,02; rsp_data=0x0081, rsp_timeout=0.
- ALU with operands: type2, A=0x10, B=0x20, fun=1; responder returns 0x00 then 0x02 -> TX CC,10,20,01; rsp_data=0x0200.
- Timeout: type3, fun=0; responder sends only 0x55 -> rsp_valid exactly TIMEOUT cycles after that byte, rsp_timeout=1, rsp_data=0x0055.
- Handshake: busy held high 50 cycles before the second byte -> no TX_D_VLD while busy=1, TX_P_Data stable; stray RX_D_VLD during send is ignored.
- Reset after the 2nd byte of a type2 command -> cmd_ready=1, TX_D_VLD=0; a new type1 command then completes normally.
